// File: rtl/seg7_scan_display_ctrl_if.sv
// Value handshake bundle for seg7_scan_display_ctrl.
// master: score/timer logic supplying values; slave: the display controller.
interface seg7_scan_display_ctrl_if #(
   parameter int VALUE_WIDTH = 14
);
   logic [VALUE_WIDTH-1:0] value_in;
   logic                   value_valid;
   logic                   value_ready;
   logic                   busy;
   logic                   overflow;

   modport master (
      output value_in,
      output value_valid,
      input  value_ready,
      input  busy,
      input  overflow
   );

   modport slave (
      input  value_in,
      input  value_valid,
      output value_ready,
      output busy,
      output overflow
   );
endinterface

// File: rtl/seg7_scan_display_ctrl.sv
// Multiplexed common-anode 7-segment controller.
// Accepts a binary value over a valid/ready handshake, converts it to BCD with a
// sequential double-dabble engine and scans NUM_DIGITS digits, leftmost first.
// Values >= 10**NUM_DIGITS show dashes on every digit and raise overflow.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (least significant digit always shown).
module seg7_scan_display_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int VALUE_WIDTH  = 14,
   parameter int DIGIT_CYCLES = 262144
) (
   input  logic                      clock_100Mhz,
   input  logic                      reset,
   seg7_scan_display_ctrl_if.slave   bus,
   output logic [NUM_DIGITS-1:0]     Anode_Activate,
   output logic [6:0]                LED_out
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int CNT_W  = $clog2(VALUE_WIDTH);
   localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CONVERT = 2'd1;
   localparam logic [1:0] S_COMMIT  = 2'd2;

   // Internal display code for a dash; never produced by the BCD engine.
   localparam logic [3:0] DASH_CODE = 4'hA;

   function automatic logic [63:0] f_pow10(input int n);
      logic [63:0] acc;
      acc = 64'd1;
      for (int i = 0; i < n; i++) acc = acc * 64'd10;
      return acc;
   endfunction

   localparam logic [63:0] LIMIT = f_pow10(NUM_DIGITS);

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'b0000001;
         4'd1:    f_decode = 7'b1001111;
         4'd2:    f_decode = 7'b0010010;
         4'd3:    f_decode = 7'b0000110;
         4'd4:    f_decode = 7'b1001100;
         4'd5:    f_decode = 7'b0100100;
         4'd6:    f_decode = 7'b0100000;
         4'd7:    f_decode = 7'b0001111;
         4'd8:    f_decode = 7'b0000000;
         4'd9:    f_decode = 7'b0000100;
         4'hA:    f_decode = 7'b1111110;
         default: f_decode = 7'b1111111;
      endcase
   endfunction

   logic [1:0]              r_state;
   logic [VALUE_WIDTH-1:0]  r_shift;
   logic [BCD_W-1:0]        r_bcd;
   logic [CNT_W-1:0]        r_bit_cnt;
   logic                    r_ovf_pend;
   logic [BCD_W-1:0]        r_disp;
   logic                    r_ovf;
   logic [TICK_W-1:0]       r_tick;
   logic [IDX_W-1:0]        r_idx;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic [6:0]              r_led;

   logic [BCD_W-1:0]        w_bcd_adj;
   logic [3:0]              w_digit;
   logic [NUM_DIGITS-1:0]   w_anode;
   logic [6:0]              w_led;

   assign bus.value_ready = (r_state == S_IDLE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.overflow    = r_ovf;
   assign Anode_Activate  = r_anode;
   assign LED_out         = r_led;

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // Handshake capture, conversion steps and atomic commit to the display register.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_bit_cnt  <= '0;
         r_ovf_pend <= 1'b0;
         r_disp     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.value_valid) begin
                  r_shift    <= bus.value_in;
                  r_bcd      <= '0;
                  r_bit_cnt  <= '0;
                  r_ovf_pend <= (64'(bus.value_in) >= LIMIT);
                  r_state    <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[VALUE_WIDTH-1]};
               r_shift <= {r_shift[VALUE_WIDTH-2:0], 1'b0};
               if (r_bit_cnt == CNT_W'(VALUE_WIDTH - 1)) begin
                  r_state <= S_COMMIT;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_COMMIT: begin
               r_disp  <= r_ovf_pend ? {NUM_DIGITS{DASH_CODE}} : r_bcd;
               r_ovf   <= r_ovf_pend;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Digit dwell counter and scan index, free-running from reset.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         r_tick <= '0;
         r_idx  <= '0;
      end else if (r_tick == TICK_W'(DIGIT_CYCLES - 1)) begin
         r_tick <= '0;
         r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

   // Select the digit for the current scan index; index 0 is the most significant nibble.
   always_comb begin
      w_digit = '0;
      w_anode = '1;
      for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
         if (IDX_W'(NUM_DIGITS - 1 - p) == r_idx) begin
            w_digit    = r_disp[4*p +: 4];
            w_anode[p] = 1'b0;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] w_lead_zero;
   logic                  w_blank;

   // Mark zero nibbles above the first non-zero nibble; bit 0 is never blanked.
   always_comb begin
      logic zero_so_far;
      zero_so_far = 1'b1;
      w_lead_zero = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         zero_so_far = zero_so_far && (r_disp[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
         if (i != NUM_DIGITS - 1) w_lead_zero[NUM_DIGITS-1-i] = zero_so_far;
      end
      w_blank = |(w_lead_zero & ~w_anode);
      w_led   = w_blank ? 7'b1111111 : f_decode(w_digit);
   end
`else
   // Every digit is decoded, leading zeros included.
   always_comb begin
      w_led = f_decode(w_digit);
   end
`endif

   // Registered anode and cathode drive.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         r_anode <= {1'b0, {(NUM_DIGITS-1){1'b1}}};
         r_led   <= 7'b0000001;
      end else begin
         r_anode <= w_anode;
         r_led   <= w_led;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display_ctrl.sv
// Self-checking bench for seg7_scan_display_ctrl (NUM_DIGITS=4, VALUE_WIDTH=14,
// DIGIT_CYCLES=4). Expected display content is derived arithmetically from the
// loaded value; the lit digit is derived from the cycle count since reset.
module tb_seg7_scan_display_ctrl;

   localparam int ND = 4;
   localparam int VW = 14;
   localparam int DC = 4;
   localparam int unsigned LIMIT = 10000;

   logic          clk;
   logic          reset;
   logic [ND-1:0] anode;
   logic [6:0]    led;
   int unsigned   cyc;
   int            n_checks;
   int            n_err;

   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   seg7_scan_display_ctrl_if #(.VALUE_WIDTH(VW)) bus ();

   seg7_scan_display_ctrl #(
      .NUM_DIGITS   (ND),
      .VALUE_WIDTH  (VW),
      .DIGIT_CYCLES (DC)
   ) dut (
      .clock_100Mhz   (clk),
      .reset          (reset),
      .bus            (bus.slave),
      .Anode_Activate (anode),
      .LED_out        (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges seen since reset was released.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned acc;
      acc = 1;
      for (int unsigned i = 0; i < n; i++) acc = acc * 10;
      return acc;
   endfunction

   // Cathode pattern for decimal position pos (0 = least significant) of value v.
   function automatic logic [6:0] exp_led(input int unsigned v, input int unsigned pos);
      int unsigned d;
      if (v >= LIMIT) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
      if (pos > 0 && v < pow10(pos)) return 7'b1111111;
`endif
      d = (v / pow10(pos)) % 10;
      return seg_tab[d];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Check the lit digit at the current sample point against value v.
   task automatic chk_now(input string tag, input int unsigned v);
      int unsigned idx;
      int unsigned pos;
      logic [ND-1:0] ea;
      idx = ((cyc - 1) / DC) % ND;
      pos = ND - 1 - idx;
      ea = '1;
      ea[pos] = 1'b0;
      chk({tag, "_anode"}, 32'(anode), 32'(ea));
      chk({tag, "_led"}, 32'(led), 32'(exp_led(v, pos)));
   endtask

   task automatic check_scan(input int n, input int unsigned v, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_now(tag, v);
      end
   endtask

   // Count negedge samples with value_ready low, bounded.
   task automatic wait_ready(output int lowcnt);
      lowcnt = 0;
      while (bus.value_ready !== 1'b1 && lowcnt < 100) begin
         lowcnt++;
         @(negedge clk);
      end
   endtask

   // Load v, check latency, old data at the ready cycle, overflow and a full scan.
   task automatic load_and_check(input int unsigned v, input int unsigned prev, input string tag);
      int lowcnt;
      @(negedge clk);
      chk({tag, "_ready_pre"}, 32'(bus.value_ready), 32'd1);
      bus.value_in    = VW'(v);
      bus.value_valid = 1'b1;
      @(negedge clk);
      bus.value_valid = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_ready(lowcnt);
      chk({tag, "_lat"}, 32'(lowcnt), 32'(VW + 1));
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(v >= LIMIT));
      chk_now({tag, "_old"}, prev);
      check_scan(ND * DC + 2, v, tag);
   endtask

   initial begin
      int          lowcnt;
      int unsigned cur;
      int unsigned rv;
      n_checks = 0;
      n_err    = 0;
      reset    = 1'b1;
      bus.value_in    = '0;
      bus.value_valid = 1'b0;

      // 1: reset state
      repeat (2) @(negedge clk);
      chk("rst_anode", 32'(anode), 32'(4'b0111));
      chk("rst_led", 32'(led), 32'(7'b0000001));
      chk("rst_ready", 32'(bus.value_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      reset = 1'b0;
      check_scan(ND * DC + 1, 0, "idle0");

      // 2: 1234
      load_and_check(1234, 0, "v1234");
      cur = 1234;

      // 3: overflow then in-range recovery
      load_and_check(10000, cur, "v10000");
      load_and_check(5, 10000, "v5");
      cur = 5;

      // 6: single digit and zero (blanking depends on build)
      load_and_check(7, cur, "v7");
      load_and_check(0, 7, "v0");
      cur = 0;

      // 4: 42 held valid while 9999 converts
      @(negedge clk);
      bus.value_in    = VW'(9999);
      bus.value_valid = 1'b1;
      @(negedge clk);
      bus.value_in    = VW'(42);
      wait_ready(lowcnt);
      chk("hold_lat", 32'(lowcnt), 32'(VW + 1));
      @(posedge clk);
      #1;
      chk("hold_capture", 32'(bus.value_ready), 32'd0);
      bus.value_valid = 1'b0;
      check_scan(16, 9999, "hold9999");
      check_scan(16, 42, "hold42");
      chk("hold_ready", 32'(bus.value_ready), 32'd1);
      cur = 42;

      // 5: reset 5 cycles into converting 9999
      @(negedge clk);
      bus.value_in    = VW'(9999);
      bus.value_valid = 1'b1;
      @(negedge clk);
      bus.value_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstmid_ready", 32'(bus.value_ready), 32'd1);
      chk("rstmid_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_scan(3 * ND * DC, 0, "rstmid_disp");
      chk("rstmid_ready2", 32'(bus.value_ready), 32'd1);
      cur = 0;

      // Random values across the whole input range, including overflow.
      for (int k = 0; k < 8; k++) begin
         rv = (k % 3 == 0) ? $urandom_range(16383, 10000) : $urandom_range(9999, 0);
         load_and_check(rv, cur, $sformatf("rnd%0d", k));
         cur = rv;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Overall time bound.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
